// File: rtl/beta_reg_file_p_if.sv
// Register-file access bundle: decode-side read addresses, writeback-side write port, busy flag.
interface beta_reg_file_p_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              busy;

   modport master (
      output ra1, ra2, we, wa, wd,
      input  rd1, rd2, busy
   );

   modport slave (
      input  ra1, ra2, we, wa, wd,
      output rd1, rd2, busy
   );
endinterface

// File: rtl/beta_reg_file_p.sv
// Beta register file: 2 async read ports, 1 sync write port, hardwired zero register, post-reset clear.
// Optional same-cycle write-to-read forwarding when BETA_RF_BYPASS_EN is defined.
module beta_reg_file_p #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 2**ADDR_W - 1
) (
   input logic              clk,
   input logic              rst,
   beta_reg_file_p_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic              busy_q;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + ADDR_W'(1);
               if (clr_ptr == LAST_A) begin
                  state  <= READY;
                  busy_q <= 1'b0;
               end
            end
            READY:   state <= READY;
            default: state <= CLEAR;
         endcase
      end
   end

   // Single array write port shared by the clear sequencer and writeback.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = bus.wa;
      mem_wd = bus.wd;
      if (!rst) begin
         if (state == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = clr_ptr;
            mem_wd = '0;
         end else if (bus.we && bus.wa != ZERO_A) begin
            mem_we = 1'b1;
         end
      end
   end

   // NOTE: the array has no reset term; the clear sequencer zeroes it, keeping it RAM-mappable.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   // Masks are applied last so they override the optional bypass.
   always_comb begin
      bus.rd1 = mem[bus.ra1];
      bus.rd2 = mem[bus.ra2];
`ifdef BETA_RF_BYPASS_EN
      if (bus.we && !busy_q && bus.wa == bus.ra1) bus.rd1 = bus.wd;
      if (bus.we && !busy_q && bus.wa == bus.ra2) bus.rd2 = bus.wd;
`else
`endif
      if (busy_q || bus.ra1 == ZERO_A) bus.rd1 = '0;
      if (busy_q || bus.ra2 == ZERO_A) bus.rd2 = '0;
   end

   assign bus.busy = busy_q;
endmodule

// File: tb/tb_beta_reg_file_p.sv
// Directed self-checking bench for beta_reg_file_p (default parameters, either bypass build).
module tb_beta_reg_file_p;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   beta_reg_file_p_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   beta_reg_file_p #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1ns after posedge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges until busy falls, bounded so a stuck sequencer cannot hang the run.
   task automatic count_busy(input string tag);
      int cnt;
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 100) begin
         step();
         cnt++;
      end
      check(tag, 32'(cnt), 32'd32);
      check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      bus.we = 1'b1;
      bus.wa = a;
      bus.wd = d;
      step();
      bus.we = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.ra1  = 5'd5;
      bus.ra2  = 5'd0;
      bus.we   = 1'b0;
      bus.wa   = 5'd0;
      bus.wd   = 32'd0;

      // Reset held three cycles: busy high, reads masked even though the array is uninitialised.
      repeat (3) step();
      check("reset_busy", {31'd0, bus.busy}, 32'd1);
      check("reset_rd1_masked", bus.rd1, 32'd0);
      check("reset_rd2_masked", bus.rd2, 32'd0);

      rst = 1'b0;
      #1;
      count_busy("clear_len");

      for (int i = 0; i < 32; i++) begin
         bus.ra1 = 5'(i);
         bus.ra2 = 5'(31 - i);
         #1;
         check($sformatf("clear_rd1_%0d", i), bus.rd1, 32'd0);
         check($sformatf("clear_rd2_%0d", 31 - i), bus.rd2, 32'd0);
      end

      // Basic write/read on both ports.
      write(5'd5, 32'hDEADBEEF);
      bus.ra1 = 5'd5;
      bus.ra2 = 5'd5;
      #1;
      check("wr5_rd1", bus.rd1, 32'hDEADBEEF);
      check("wr5_rd2", bus.rd2, 32'hDEADBEEF);
      write(5'd6, 32'h12345678);
      bus.ra2 = 5'd6;
      #1;
      check("wr6_rd1_keeps5", bus.rd1, 32'hDEADBEEF);
      check("wr6_rd2", bus.rd2, 32'h12345678);

      // Zero register write is dropped; neighbour untouched.
      write(5'd31, 32'hFFFFFFFF);
      bus.ra1 = 5'd31;
      bus.ra2 = 5'd30;
      #1;
      check("zero_rd1", bus.rd1, 32'd0);
      check("zero_nbr_rd2", bus.rd2, 32'd0);

      // Same-cycle write/read hazard.
      write(5'd7, 32'd1);
      bus.we  = 1'b1;
      bus.wa  = 5'd7;
      bus.wd  = 32'd2;
      bus.ra1 = 5'd7;
      #1;
`ifdef BETA_RF_BYPASS_EN
      check("hazard_pre_edge", bus.rd1, 32'd2);
`else
      check("hazard_pre_edge", bus.rd1, 32'd1);
`endif
      step();
      bus.we = 1'b0;
      #1;
      check("hazard_post_edge", bus.rd1, 32'd2);

      // Reset mid-clear: restart from 0 and take a full 32 cycles after second release.
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (20) step();
      check("midclear_still_busy", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("reclear_busy", {31'd0, bus.busy}, 32'd1);

      // Inline busy count so a write can be injected in cycle 10 of the clear.
      begin
         int cnt;
         cnt = 0;
         bus.ra1 = 5'd5;
         while (bus.busy === 1'b1 && cnt < 100) begin
            if (cnt == 10) begin
               bus.we = 1'b1;
               bus.wa = 5'd2;
               bus.wd = 32'hAAAA5555;
               #1;
               check("clear_rd1_masked", bus.rd1, 32'd0);
            end else begin
               bus.we = 1'b0;
            end
            step();
            cnt++;
         end
         bus.we = 1'b0;
         check("reclear_len", 32'(cnt), 32'd32);
      end

      bus.ra1 = 5'd2;
      bus.ra2 = 5'd5;
      #1;
      check("clear_write_dropped", bus.rd1, 32'd0);
      check("reclear_zeroed5", bus.rd2, 32'd0);
      bus.ra2 = 5'd7;
      #1;
      check("reclear_zeroed7", bus.rd2, 32'd0);

      // Array usable again after re-clear.
      write(5'd2, 32'hCAFEF00D);
      #1;
      check("post_reclear_wr2", bus.rd1, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/beta_reg_file_p.md
Name: beta_reg_file_p

Overview:
- Parametrised next-generation register file for the Beta CPU: two asynchronous read ports, one synchronous write port.
- Configurable data width and address width. The zero register (default R31) is hardwired: reads return 0 and writes are dropped.
- Adds a post-reset clear sequencer that zeroes every entry one per cycle, flagged by busy.
- Optional write-to-read bypass for same-cycle forwarding.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

Parameters:
- DATA_W, 32, width of each register and of rd1/rd2/wd.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 2**ADDR_W-1, index of the hardwired-zero register (31 at defaults).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ra1  in  ADDR_W  read address, port 1.
- ra2  in  ADDR_W  read address, port 2.
- rd1  out  DATA_W  read data, port 1 (combinational from ra1).
- rd2  out  DATA_W  read data, port 2 (combinational from ra2).
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- busy  out  1  high while the clear sequencer runs; writes are ignored and reads return 0.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Nothing happens asynchronously to clk except combinational reads.
- State machine: two states, CLEAR and READY, plus clr_ptr (ADDR_W bits).
- While rst is high at a clk edge:
  - state <= CLEAR, clr_ptr <= 0, busy = 1.
  - No array write occurs on that edge.
- CLEAR, rst low, each edge:
  - mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr + 1.
  - When clr_ptr == DEPTH-1, that edge writes the last entry and state <= READY.
  - busy stays 1 through the cycle ending at that edge. It is 0 from the next cycle, so busy lasts exactly DEPTH cycles after rst deasserts.
  - clr_ptr wraps to 0 on that edge and is held while READY.
- READY: state persists until rst.
- Reset mid-clear: the sequence restarts from clr_ptr=0 and takes a full DEPTH cycles after the new deassertion.
- Reset values / busy-time outputs:
  - busy = 1.
  - rd1 = rd2 = 0 while busy, regardless of ra1/ra2.
- Write, READY only:
  - If we && wa != ZERO_REG, then mem[wa] <= wd on the rising edge.
  - we during CLEAR is dropped silently and not queued.
- Read:
  - rdN = 0 if raN == ZERO_REG or busy; otherwise mem[raN].
  - Combinational, zero latency.
- Write/read same address, same cycle, without bypass: rdN shows the old value; the new value is visible the cycle after the edge.
- Both read ports may address the same entry. Each port is independent.
- No X ever propagates to rd1/rd2 after the clear completes.

Optional Feature:
- Macro: BETA_RF_BYPASS_EN.
- Defined: rdN = wd combinationally when we && !busy && wa == raN && raN != ZERO_REG. Bypass priority is below the zero-register and busy masks.
- Undefined: no forwarding; same-cycle reads return the stored value, as described in Behaviour.

Test Plan:
- Clear sequence: assert rst 3 cycles, then release. Required: busy=1 for exactly 32 cycles after release, then 0. Then read all 32 addresses and require 0 on both ports.
- Basic write/read: we=1, wa=5, wd=32'hDEADBEEF, one edge. Then ra1=5, ra2=5: both return 32'hDEADBEEF. Then write wa=6, wd=32'h12345678: ra1=5 still returns 32'hDEADBEEF and ra2=6 returns 32'h12345678.
- Zero register: write wa=31, wd=32'hFFFFFFFF. Required: ra1=31 reads 0, and ra2=30 is unchanged (0 after clear).
- Write during clear: drive we=1, wa=2, wd=32'hAAAA5555 in cycle 10 of the clear. Required: after busy falls, ra1=2 reads 0.
- Reset mid-clear: release rst, wait 20 cycles, reassert rst 1 cycle, release. Required: busy=1 for 32 cycles after the second release.
- Same-cycle hazard: mem[7]=1, then drive we=1, wa=7, wd=2, ra1=7 in the same cycle. Required before the edge: rd1=2 with BETA_RF_BYPASS_EN, rd1=1 without it. Required after the edge: rd1=2 in both builds.
